and_dff_checker: RTL and testbench

- Synthesizable stimulus/response checker for the registered-AND flip-flop block.
- On `start`, drives every `{a,b}` combination into the flop for a configurable number of sweeps.
- Samples the flop's `q` output, compares it with the expected registered AND of each vector, and counts mismatches.
- Reports a pass/fail verdict.
- Serves as the on-chip counterpart to the flop: it drives the flop's inputs, reads its output and judges it. It sits beside the flop in bring-up and BIST builds.

---
 rtl/and_dff_checker_if.sv | 25 ++
 rtl/and_dff_checker.sv | 154 +++++++++++++++
 tb/tb_and_dff_checker.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/and_dff_checker_if.sv
// Signal bundle between the AND-flop checker and its surroundings.
// master: the checker side (drives stimulus and verdict, reads start and q).
// slave:  the environment side (drives start and the flop's q, reads the rest).
interface and_dff_checker_if #(
  parameter int unsigned ERR_W = 8
) ();
  logic             start;
  logic             q_in;
  logic             a_out;
  logic             b_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;

  modport master (
    input  start, q_in,
    output a_out, b_out, busy, done, pass, err_count
  );

  modport slave (
    output start, q_in,
    input  a_out, b_out, busy, done, pass, err_count
  );
endinterface

// File: rtl/and_dff_checker.sv
// Stimulus/response checker for a registered-AND flop.
// Sweeps {a,b} = 00,01,10,11 PASSES times, compares the flop's q (LAT edges
// after launch) against a&b, counts mismatches (saturating) and reports pass.
// Optional build macro AND_CHK_STOP_ON_ERR_EN: the first mismatch ends the run.
module and_dff_checker #(
  parameter int unsigned PASSES = 4,
  parameter int unsigned LAT    = 1,
  parameter int unsigned ERR_W  = 8
) (
  input logic                clk,
  input logic                reset,
  and_dff_checker_if.master  chk
);

  localparam int unsigned N    = 4 * PASSES;
  localparam int unsigned IdxW = $clog2(N);
  localparam int unsigned CntW = $clog2(LAT + 1) + 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StDrive = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [IdxW-1:0] LastIdx   = IdxW'(N - 1);
  localparam logic [CntW-1:0] DrainLast = CntW'(LAT);

  logic [1:0]       state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [CntW-1:0]  drain_q, drain_d;
  logic [LAT:0]     vld_q, vld_d;
  logic [LAT:0]     exp_q, exp_d;
  logic             mis_q, mis_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             a_q, a_d, b_q, b_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;

  logic             launch;
  logic [IdxW-1:0]  launch_idx;
  logic             flush;

  // Next-state: FSM, vector launch, check pipeline and mismatch counter.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    drain_d    = drain_q;
    err_d      = err_q;
    launch     = 1'b0;
    launch_idx = idx_q;
    flush      = 1'b0;

    // Compare registered here; the counter absorbs it one edge later.
    mis_d = vld_q[LAT] & (exp_q[LAT] ^ chk.q_in);
    if (mis_q && (err_q != {ERR_W{1'b1}})) begin
      err_d = err_q + 1'b1;
    end

    case (state_q)
      StIdle, StDone: begin
        if (chk.start) begin
          state_d    = StDrive;
          idx_d      = '0;
          err_d      = '0;
          launch     = 1'b1;
          launch_idx = '0;
          flush      = 1'b1;
        end
      end
      StDrive: begin
        if (idx_q == LastIdx) begin
          state_d = StDrain;
          drain_d = '0;
        end else begin
          idx_d      = idx_q + 1'b1;
          launch     = 1'b1;
          launch_idx = idx_q + 1'b1;
        end
      end
      StDrain: begin
        if (drain_q == DrainLast) begin
          state_d = StDone;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef AND_CHK_STOP_ON_ERR_EN
    // First registered mismatch aborts: verdict now, in-flight entries dropped.
    if (mis_q && ((state_q == StDrive) || (state_q == StDrain))) begin
      state_d = StDone;
      launch  = 1'b0;
      flush   = 1'b1;
    end
`endif

    if (flush) begin
      vld_d = {{LAT{1'b0}}, launch};
      exp_d = {{LAT{1'b0}}, launch & (&launch_idx[1:0])};
      mis_d = 1'b0;
    end else begin
      vld_d = {vld_q[LAT-1:0], launch};
      exp_d = {exp_q[LAT-1:0], launch & (&launch_idx[1:0])};
    end

    a_d    = launch & launch_idx[1];
    b_d    = launch & launch_idx[0];
    busy_d = (state_d == StDrive) || (state_d == StDrain);
    done_d = (state_d == StDone);
    pass_d = done_d && (err_d == '0);
  end

  // State and registered outputs; reset discards any partial run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      drain_q <= '0;
      vld_q   <= '0;
      exp_q   <= '0;
      mis_q   <= 1'b0;
      err_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drain_q <= drain_d;
      vld_q   <= vld_d;
      exp_q   <= exp_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // Drive the bundle straight from flops.
  always_comb begin
    chk.a_out     = a_q;
    chk.b_out     = b_q;
    chk.busy      = busy_q;
    chk.done      = done_q;
    chk.pass      = pass_q;
    chk.err_count = err_q;
  end

endmodule

// File: tb/tb_and_dff_checker.sv
// Bench for and_dff_checker: two checkers (ERR_W 8 and 2) share one behavioural
// flop with selectable faults; per-run expectations go into a scoreboard queue
// that a monitor pops when done rises.
module tb_and_dff_checker;

  localparam int unsigned PASSES = 4;
  localparam int unsigned LAT    = 1;
  localparam int unsigned EW0    = 8;
  localparam int unsigned EW1    = 2;
  localparam int unsigned N      = 4 * PASSES;

  typedef struct {
    int err0;
    int err1;
    int pass;
    int busy_len;
    int n_vec;
  } rec_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         kick = 1'b0;
  int           fm = 0;           // 0 good (+mask flips), 1 stuck-at-1, 2 stuck-at-0
  logic [N-1:0] mask = '0;
  logic [LAT-1:0] fst = '0;
  int           cap_k = N;
  logic         corr;
  logic         q_flop;

  int checks = 0;
  int failures = 0;
  rec_t sb[$];

  and_dff_checker_if #(.ERR_W(EW0)) if0 ();
  and_dff_checker_if #(.ERR_W(EW1)) if1 ();

  and_dff_checker #(.PASSES(PASSES), .LAT(LAT), .ERR_W(EW0)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .chk   (if0.master)
  );

  and_dff_checker #(.PASSES(PASSES), .LAT(LAT), .ERR_W(EW1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .chk   (if1.master)
  );

  always #5 clk = ~clk;

  // Behavioural flop under check, driven by checker 0's stimulus.
  assign corr   = (cap_k < N) ? mask[cap_k] : 1'b0;
  assign q_flop = (fm == 1) ? 1'b1 : (fm == 2) ? 1'b0 : fst[LAT-1];
  assign if0.start = start;
  assign if1.start = start;
  assign if0.q_in  = q_flop;
  assign if1.q_in  = q_flop;

  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) fst[i] <= fst[i-1];
    fst[0] <= (if0.a_out & if0.b_out) ^ corr;
    if (kick) cap_k <= 0;
    else if (cap_k < N) cap_k <= cap_k + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: vector k carries a=k[1], b=k[0]; flop should return a&b.
  function automatic rec_t model(input int mode, input logic [N-1:0] m);
    rec_t r;
    int   cnt = 0;
    int   first = -1;
    bit   e, qv;
    for (int k = 0; k < N; k++) begin
      e  = ((k % 4) == 3);
      qv = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : (e ^ m[k]);
      if (qv != e) begin
        cnt++;
        if (first < 0) first = k;
      end
    end
`ifdef AND_CHK_STOP_ON_ERR_EN
    if (first >= 0) begin
      r.err0     = 1;
      r.err1     = 1;
      r.pass     = 0;
      r.busy_len = first + LAT + 2;
      r.n_vec    = (first + LAT + 2 < N) ? first + LAT + 2 : N;
      return r;
    end
`endif
    r.err0     = (cnt > (1 << EW0) - 1) ? (1 << EW0) - 1 : cnt;
    r.err1     = (cnt > (1 << EW1) - 1) ? (1 << EW1) - 1 : cnt;
    r.pass     = (cnt == 0) ? 1 : 0;
    r.busy_len = N + LAT + 1;
    r.n_vec    = N;
    return r;
  endfunction

  // Monitor: checks the vector stream while busy and the verdict when done rises.
  initial begin
    int   vk = 0;
    int   bcnt = 0;
    logic done_prev = 1'b0;
    rec_t r;
    forever begin
      @(negedge clk);
      if (!reset) begin
        vk = 0;
        bcnt = 0;
        done_prev = 1'b0;
        continue;
      end
      if (if0.busy) begin
        bcnt++;
        if (sb.size() > 0) begin
          check("vector_ab", int'({if0.a_out, if0.b_out}),
                (vk < sb[0].n_vec) ? (vk % 4) : 0);
        end
        vk++;
      end
      if (if0.done && !done_prev) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          r = sb.pop_front();
          check("err_count0", int'(if0.err_count), r.err0);
          check("err_count1", int'(if1.err_count), r.err1);
          check("pass0", int'(if0.pass), r.pass);
          check("pass1", int'(if1.pass), r.pass);
          check("done1", int'(if1.done), 1);
          check("busy_cycles", bcnt, r.busy_len);
        end
        bcnt = 0;
        vk = 0;
      end
      done_prev = if0.done;
    end
  end

  task automatic wait_done(input string name);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (if0.done) break;
    end
    check(name, int'(if0.done), 1);
  endtask

  task automatic kick_start();
    @(negedge clk);
    start = 1'b1;
    kick  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    kick  = 1'b0;
  endtask

  task automatic run_one(input int mode, input logic [N-1:0] m);
    fm   = mode;
    mask = m;
    sb.push_back(model(mode, m));
    kick_start();
    wait_done("run_done_timeout");
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_a"}, int'(if0.a_out), 0);
    check({tag, "_b"}, int'(if0.b_out), 0);
    check({tag, "_busy"}, int'(if0.busy), 0);
    check({tag, "_done"}, int'(if0.done), 0);
    check({tag, "_pass"}, int'(if0.pass), 0);
    check({tag, "_err0"}, int'(if0.err_count), 0);
    check({tag, "_err1"}, int'(if1.err_count), 0);
  endtask

  initial begin
    logic [N-1:0] m;
    int mode;

    repeat (2) @(negedge clk);
    check_zero("reset_state");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Directed: good flop, stuck-at-1, stuck-at-0 (saturates the 2-bit counter).
    run_one(0, '0);
    run_one(1, '0);
    run_one(2, '0);

    // Reset mid-run at vector 7 discards the run; a clean run afterwards passes.
    fm = 1;
    mask = '0;
    sb.push_back(model(1, '0));
    kick_start();
    repeat (7) @(negedge clk);
    #2 reset = 1'b0;
    sb.delete();
    #1 check_zero("async_reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_one(0, '0);

    // Mid-run start pulse ignored; start held through DONE restarts with a cleared count.
    fm = 2;
    mask = '0;
    sb.push_back(model(2, '0));
    sb.push_back(model(2, '0));
    kick_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    wait_done("hold_first_done");
    kick = 1'b1;
    @(negedge clk);
    kick  = 1'b0;
    start = 1'b0;
    check("restart_err0", int'(if0.err_count), 0);
    check("restart_busy", int'(if0.busy), 1);
    check("restart_done", int'(if0.done), 0);
    wait_done("hold_second_done");

    // Randomised fault patterns.
    for (int r = 0; r < 12; r++) begin
      mode = $urandom_range(0, 2);
      m = '0;
      if (mode == 0 && $urandom_range(0, 3) != 0) m = N'($urandom) & N'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_one(mode, m);
    end

    repeat (4) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
